// File: rtl/batch_sweep_scheduler.sv
// -----------------------------------------------------------------------------
// batch_sweep_scheduler
//
// Purpose:
//   Steps the coincidence batch monitor through every selection code
//   0..NUM_SEL-1. For each code it arms the monitor with a one-cycle
//   batch_start pulse and waits for batch_done. It then captures the batch
//   count and offers it to the readout path over a valid/ready handshake.
//   After the word transfers it moves to the next code. It keeps sweeping
//   while run_en stays high.
//
// Optional feature macro:
//   BATCH_WDOG_EN - adds a per-batch watchdog. A batch that runs for
//   TIMEOUT_CYC cycles with no batch_done is closed with an all-ones count,
//   and the sticky timeout_err flag is set. Without the macro, RUN waits
//   indefinitely and timeout_err stays 0.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   run_en       in   level; high = sweep continuously, low = stop after the
//                     current word has been read out
//   abort        in   synchronous abort back to IDLE
//   batch_done   in   one-cycle completion pulse from the monitor
//   batch_count  in   monitor count, valid with batch_done
//   rd_ready     in   readout sink ready
//   selection    out  selection code driven to the monitor
//   batch_start  out  one-cycle start pulse to the monitor
//   rd_valid     out  readout word valid
//   rd_sel       out  selection code of the readout word
//   rd_count     out  captured batch count
//   sweep_done   out  one-cycle pulse after the last code's word transfers
//   busy         out  high whenever the FSM is not in IDLE
//   timeout_err  out  sticky watchdog flag
// -----------------------------------------------------------------------------
module batch_sweep_scheduler #(
    parameter int NUM_SEL     = 9,
    parameter int SEL_W       = 4,
    parameter int COUNT_W     = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    input  logic               abort,
    input  logic               batch_done,
    input  logic [COUNT_W-1:0] batch_count,
    input  logic               rd_ready,
    output logic [SEL_W-1:0]   selection,
    output logic               batch_start,
    output logic               rd_valid,
    output logic [SEL_W-1:0]   rd_sel,
    output logic [COUNT_W-1:0] rd_count,
    output logic               sweep_done,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_RUN     = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0]   LAST_SEL  = SEL_W'(NUM_SEL - 1);
    localparam logic [SEL_W-1:0]   SEL_ZERO  = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0]   SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] CNT_ZERO  = {COUNT_W{1'b0}};
    localparam logic [COUNT_W-1:0] CNT_ONES  = {COUNT_W{1'b1}};

    state_t state_r;
    logic   xfer_s;       // readout word accepted this cycle
    logic   last_s;       // current code is the final one of the sweep
    logic   wdog_hit_s;   // watchdog closes the current batch this cycle

    // Handshake and end-of-sweep decode.
    always_comb begin
        xfer_s = rd_valid & rd_ready;
        last_s = (selection == LAST_SEL);
    end

`ifdef BATCH_WDOG_EN
    localparam int                WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]   WD_ZERO  = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]   WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wdog_cnt_r;

    // Batch watchdog counter: cleared while arming, counts RUN cycles.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wdog_cnt_r <= WD_ZERO;
        end else if (state_r == ST_ARM) begin
            wdog_cnt_r <= WD_ZERO;
        end else if (state_r == ST_RUN) begin
            wdog_cnt_r <= wdog_cnt_r + WD_ONE;
        end else begin
            wdog_cnt_r <= wdog_cnt_r;
        end
    end

    // The limit is TIMEOUT_CYC-1 because the count starts at 0 in the first
    // RUN cycle. The batch therefore closes in its TIMEOUT_CYC-th RUN cycle.
    always_comb begin
        if ((state_r == ST_RUN) && (wdog_cnt_r == WD_LIMIT)) begin
            wdog_hit_s = 1'b1;
        end else begin
            wdog_hit_s = 1'b0;
        end
    end
`else
    // No watchdog: RUN waits for batch_done indefinitely.
    always_comb begin
        wdog_hit_s = 1'b0;
    end
`endif

    // Main sequencing FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            selection   <= SEL_ZERO;
            batch_start <= 1'b0;
            rd_valid    <= 1'b0;
            rd_sel      <= SEL_ZERO;
            rd_count    <= CNT_ZERO;
            sweep_done  <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else if (abort) begin
            // The pending word is dropped. rd_sel, rd_count and timeout_err
            // keep their values.
            state_r     <= ST_IDLE;
            selection   <= SEL_ZERO;
            batch_start <= 1'b0;
            rd_valid    <= 1'b0;
            sweep_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Both pulses default low; the transitions below raise them.
            batch_start <= 1'b0;
            sweep_done  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (run_en) begin
                        state_r     <= ST_ARM;
                        selection   <= SEL_ZERO;
                        batch_start <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end else begin
                        busy        <= 1'b0;
                    end
                end
                ST_ARM: begin
                    // batch_start is high for exactly this cycle.
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (batch_done) begin
                        state_r  <= ST_READOUT;
                        rd_count <= batch_count;
                        rd_sel   <= selection;
                        rd_valid <= 1'b1;
                    end else if (wdog_hit_s) begin
                        state_r     <= ST_READOUT;
                        rd_count    <= CNT_ONES;
                        rd_sel      <= selection;
                        rd_valid    <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_READOUT: begin
                    if (xfer_s) begin
                        rd_valid <= 1'b0;
                        if (last_s) begin
                            // End of sweep: wrap to code 0 and flag it.
                            selection  <= SEL_ZERO;
                            sweep_done <= 1'b1;
                            if (run_en) begin
                                state_r     <= ST_ARM;
                                batch_start <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                                busy    <= 1'b0;
                            end
                        end else if (run_en) begin
                            state_r     <= ST_ARM;
                            selection   <= selection + SEL_ONE;
                            batch_start <= 1'b1;
                        end else begin
                            // Sweep stopped partway: no sweep_done pulse.
                            state_r   <= ST_IDLE;
                            selection <= SEL_ZERO;
                            busy      <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_READOUT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    selection   <= SEL_ZERO;
                    rd_valid    <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
